// File: rtl/regfile_write_arbiter_if.sv
// Write-back bus between the ALU/MDU result sources and the register file write arbiter.
// The sources hold the master side; the arbiter sits on the slave side.
interface regfile_write_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 alu_valid;
  logic [REG_AW-1:0]    alu_reg;
  logic [DATA_W-1:0]    alu_data;
  logic                 mdu_valid;
  logic                 mdu_ready;
  logic [REG_AW-1:0]    mdu_reg;
  logic [DATA_W-1:0]    mdu_data;
  logic [REG_AW-1:0]    write_reg;
  logic [DATA_W-1:0]    write_data;
  logic                 regWrite;
  logic [2**REG_AW-1:0] pending_mask;
  logic [CNT_W-1:0]     fifo_count;

  modport master (
    output alu_valid, alu_reg, alu_data, mdu_valid, mdu_reg, mdu_data,
    input  mdu_ready, write_reg, write_data, regWrite, pending_mask, fifo_count
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, mdu_valid, mdu_reg, mdu_data,
    output mdu_ready, write_reg, write_data, regWrite, pending_mask, fifo_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Merges ALU and queued MDU results into one register file write per cycle.
// ALU writes win outright and kill older queued MDU results to the same register.
module regfile_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic                   clk,
  input logic                   reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**REG_AW;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [REG_AW-1:0] fifo_reg  [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [DEPTH-1:0]  live;
  logic [DEPTH-1:0]  live_next;
  logic [DEPTH-1:0]  kill;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [NREG-1:0]   mask;

  logic alu_write;
  logic push;
  logic pop;
  logic push_live;
  logic head_writes;

  // A dropped r0 ALU result still occupies the port and blocks the pop.
  assign alu_write   = bus.alu_valid && (bus.alu_reg != '0);
  assign push        = bus.mdu_valid && (count < FULL);
  assign pop         = !bus.alu_valid && (count != '0);
  assign push_live   = !(alu_write && (bus.mdu_reg == bus.alu_reg));
  assign head_writes = live[rd_ptr] && (fifo_reg[rd_ptr] != '0);

  always_comb begin
    kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = alu_write && (fifo_reg[i] == bus.alu_reg);
    end
  end

  // Pop and push never share a slot: popping needs count>0, pushing needs count<DEPTH.
  always_comb begin
    live_next = live & ~kill;
    if (pop) begin
      live_next[rd_ptr] = 1'b0;
    end
    if (push) begin
      live_next[wr_ptr] = push_live;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= bus.mdu_reg;
      fifo_data[wr_ptr] <= bus.mdu_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      live <= live_next;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Killed or r0 heads are popped silently; address and data keep their last values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.regWrite   <= 1'b0;
      bus.write_reg  <= '0;
      bus.write_data <= '0;
    end else if (alu_write) begin
      bus.regWrite   <= 1'b1;
      bus.write_reg  <= bus.alu_reg;
      bus.write_data <= bus.alu_data;
    end else if (pop && head_writes) begin
      bus.regWrite   <= 1'b1;
      bus.write_reg  <= fifo_reg[rd_ptr];
      bus.write_data <= fifo_data[rd_ptr];
    end else begin
      bus.regWrite   <= 1'b0;
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i]) begin
        mask[fifo_reg[i]] = 1'b1;
      end
    end
    mask[0] = 1'b0;
  end

  assign bus.pending_mask = mask;
  assign bus.fifo_count   = count;
  assign bus.mdu_ready    = (count < FULL);
endmodule
